rv_iommu_pdtc_ctrl: RTL and testbench
=====================================

// Module: rv_iommu_pdtc_ctrl
// PURPOSE
//  Sequencer/arbiter in front of the 4-entry PDT cache (rv_iommu_pdtc).
//  - Serializes three requesters onto the cache's level/done 4-phase handshake:
//    translation lookups, PDT-walker fills and IODIR.INVAL_PDT flushes.
//  - Registers all request data; returns lookup results over a valid/ready response channel.
// PARAMETERS
//  STARVE_MAX   4    consecutive flush/fill grants while a lookup waits before the lookup is forced next
//  TIMEOUT_CYC  64   cycles to wait for a cache done edge (only with RV_IOMMU_PDTC_TIMEOUT_EN)
// PORTS
//  clk                 in   1   clock
//  rst_n               in   1   asynchronous active-low reset
//  lkup_valid_i/ready_o in/out 1 lookup request handshake
//  lkup_did_i/pid_i    in   24/20 lookup device_id / process_id
//  rsp_valid_o/ready_i out/in 1 lookup response handshake
//  rsp_hit_o           out  1   cache hit
//  rsp_ctx_o           out  60  pdtc_ctx_t {ens,sum,pscid[19:0],fsc_mode[3:0],fsc_ppn[33:0]}; 0 on miss
//  fill_valid_i/ready_o in/out 1 fill request handshake (PDT walker)
//  fill_did_i/pid_i    in   24/20 fill tags
//  fill_ctx_i          in   60  fill context (pdtc_ctx_t)
//  inv_valid_i/ready_o in/out 1 flush request handshake (command queue)
//  inv_did_i/pid_i     in   24/20 flush tags
//  inv_done_o          out  1   1-cycle pulse when flush completes
//  pdtc_lookup_o/fill_o/flush_o out 1 cache request levels
//  pdtc_did_o/pid_o    out  24/20 lookup/fill tags to cache (also driven on flush tag ports)
//  pdtc_ctx_o          out  60  fill data to cache
//  pdtc_lkup_fill_done_i, pdtc_hit_i, pdtc_flush_done_i in 1 cache status
//  pdtc_ctx_i          in   60  cache hit-row context
//  err_timeout_o       out  1   sticky; set on handshake timeout (0 when macro undefined)
// BEHAVIOUR
//  - Reset: FSM=IDLE; all *_ready_o, rsp_valid_o, inv_done_o, pdtc_*_o requests, err_timeout_o = 0; starve_cnt=0.
//  - FSM: IDLE -> {FLUSH|FILL|LOOKUP} -> DROP -> (RSP for lookup) -> IDLE.
//  - IDLE arbitration, one grant per op: inv > fill > lkup.
//    - Exception: starve_cnt==STARVE_MAX and lkup_valid_i grants lookup.
//  - Grant: matching *_ready_o high exactly one cycle; request fields registered; next state asserts cache request.
//  - Starvation counter:
//    - starve_cnt++ (saturating) on each inv/fill grant while lkup_valid_i=1.
//    - Cleared on lookup grant or when lkup_valid_i=0.
//  - LOOKUP/FILL: hold pdtc_lookup_o / pdtc_fill_o with stable data until pdtc_lkup_fill_done_i=1.
//    - Lookup also captures pdtc_hit_i; on hit captures pdtc_ctx_i.
//  - FLUSH: hold pdtc_flush_o until pdtc_flush_done_i=1.
//  - Exactly one cache request level asserted at any time; the other two are 0.
//  - DROP: request deasserted; wait for the matching done=0 (4-phase completion).
//    - Flush then pulses inv_done_o and returns to IDLE.
//  - RSP: rsp_valid_o held with rsp_hit_o/rsp_ctx_o stable until rsp_ready_i; no new grant while in RSP.
//  - Minimum op: grant(1) + request(>=1) + drop(>=1) cycles; back-to-back ops legal from the following IDLE cycle.
//  - Simultaneous valids: only the winner's ready rises; losers hold valid (requester rule: valid and data stable until ready).
//  - Done asserted outside the matching state: ignored.
//  - Async reset mid-op: all request levels drop immediately; the cache is reset with the same rst_n.
// CONFIGURATION
//  - `RV_IOMMU_PDTC_TIMEOUT_EN defined:
//    - 16-bit counter runs in request/drop states; reaches TIMEOUT_CYC -> drop request, set err_timeout_o, go to IDLE.
//    - Aborted lookup returns rsp_hit_o=0; aborted flush still pulses inv_done_o.
//  - Undefined: no counter; waits forever; err_timeout_o tied 0.
// STRUCTURE
//  - rv_iommu_pkg:
//    - pdtc_ctx_t packed struct
//    - pdtc_ctrl_state_e (IDLE,LOOKUP,FILL,FLUSH,DROP,RSP)
//    - DID_W=24, PID_W=20 constants
//  - One sub-module, rv_iommu_pdtc_arb: 3-way fixed-priority pick with starvation override (combinational + starve_cnt).
// TESTING
//  - Lookup miss: lkup did=0x12,pid=0x5 on empty cache -> rsp_valid, hit=0, ctx=0; pdtc_lookup_o high until done, then low.
//  - Fill then lookup same tags, fsc_ppn=0x2_0000_1234 -> rsp hit=1, rsp_ctx_o.fsc_ppn=0x2_0000_1234.
//  - inv, fill, lkup valid same cycle -> grant order flush, fill, lookup; never two pdtc_*_o high.
//  - Starvation: lkup held, fills continuously -> lookup granted after exactly STARVE_MAX=4 fills.
//  - Flush of filled entry then lookup -> inv_done_o pulse, lookup hit=0.
//  - With macro: cache stub never raises done -> err_timeout_o=1 after 64 cycles, rsp hit=0; rst_n low mid-LOOKUP -> all outputs 0.

Source files
------------

// File: rtl/rv_iommu_pkg.sv
// rv_iommu_pkg: shared types and constants for the PDT cache controller
package rv_iommu_pkg;
    localparam int DID_W       = 24;
    localparam int PID_W       = 20;
    localparam int STARVE_MAX  = 4;
    localparam int TIMEOUT_CYC = 64;

    typedef struct packed {
        logic        ens;
        logic        sum;
        logic [19:0] pscid;
        logic [3:0]  fsc_mode;
        logic [33:0] fsc_ppn;
    } pdtc_ctx_t;

    localparam int CTX_W = $bits(pdtc_ctx_t);

    typedef enum logic [2:0] {IDLE, LOOKUP, FILL, FLUSH, DROP, RSP} pdtc_ctrl_state_e;
endpackage

// File: rtl/rv_iommu_pdtc_arb.sv
// rv_iommu_pdtc_arb: fixed-priority flush > fill > lookup pick with lookup starvation override
module rv_iommu_pdtc_arb
    import rv_iommu_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic inv_req,
    input  logic fill_req,
    input  logic lkup_req,
    output logic inv_gnt,
    output logic fill_gnt,
    output logic lkup_gnt
);
    localparam int SC_W = $clog2(STARVE_MAX + 1);

    logic [SC_W-1:0] starve_cnt;
    logic            force_lkup;

    assign force_lkup = lkup_req && starve_cnt == SC_W'(STARVE_MAX);
    assign inv_gnt    = en && inv_req && !force_lkup;
    assign fill_gnt   = en && fill_req && !inv_req && !force_lkup;
    assign lkup_gnt   = en && lkup_req && (force_lkup || (!inv_req && !fill_req));

    // a flush/fill grant implies the counter is below the cap, so the increment saturates
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            starve_cnt <= '0;
        else if (!lkup_req || lkup_gnt)
            starve_cnt <= '0;
        else if (inv_gnt || fill_gnt)
            starve_cnt <= starve_cnt + 1'b1;
    end
endmodule

// File: rtl/rv_iommu_pdtc_ctrl.sv
// rv_iommu_pdtc_ctrl: serializes lookup/fill/flush requesters onto the PDT cache 4-phase handshake.
// Optional handshake timeout with abort is enabled by RV_IOMMU_PDTC_TIMEOUT_EN.
module rv_iommu_pdtc_ctrl
    import rv_iommu_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             lkup_valid_i,
    output logic             lkup_ready_o,
    input  logic [DID_W-1:0] lkup_did_i,
    input  logic [PID_W-1:0] lkup_pid_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic             rsp_hit_o,
    output logic [CTX_W-1:0] rsp_ctx_o,
    input  logic             fill_valid_i,
    output logic             fill_ready_o,
    input  logic [DID_W-1:0] fill_did_i,
    input  logic [PID_W-1:0] fill_pid_i,
    input  logic [CTX_W-1:0] fill_ctx_i,
    input  logic             inv_valid_i,
    output logic             inv_ready_o,
    input  logic [DID_W-1:0] inv_did_i,
    input  logic [PID_W-1:0] inv_pid_i,
    output logic             inv_done_o,
    output logic             pdtc_lookup_o,
    output logic             pdtc_fill_o,
    output logic             pdtc_flush_o,
    output logic [DID_W-1:0] pdtc_did_o,
    output logic [PID_W-1:0] pdtc_pid_o,
    output logic [CTX_W-1:0] pdtc_ctx_o,
    input  logic             pdtc_lkup_fill_done_i,
    input  logic             pdtc_hit_i,
    input  logic             pdtc_flush_done_i,
    input  logic [CTX_W-1:0] pdtc_ctx_i,
    output logic             err_timeout_o
);
    pdtc_ctrl_state_e state_q, state_d, op_q;
    logic [DID_W-1:0] did_q;
    logic [PID_W-1:0] pid_q;
    pdtc_ctx_t        fill_ctx_q, rsp_ctx_q;
    logic             hit_q;
    logic             inv_gnt, fill_gnt, lkup_gnt;
    logic             req_st, busy, op_done, drop_clr, fin, tmo;

    rv_iommu_pdtc_arb u_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (state_q == IDLE),
        .inv_req  (inv_valid_i),
        .fill_req (fill_valid_i),
        .lkup_req (lkup_valid_i),
        .inv_gnt  (inv_gnt),
        .fill_gnt (fill_gnt),
        .lkup_gnt (lkup_gnt)
    );

    assign req_st   = state_q == LOOKUP || state_q == FILL || state_q == FLUSH;
    assign busy     = req_st || state_q == DROP;
    assign op_done  = (op_q == FLUSH) ? pdtc_flush_done_i : pdtc_lkup_fill_done_i;
    assign drop_clr = state_q == DROP && !op_done;
    assign fin      = busy && (tmo || drop_clr);

`ifdef RV_IOMMU_PDTC_TIMEOUT_EN
    logic [15:0] tmo_cnt;
    logic        err_q;

    assign tmo           = busy && tmo_cnt == 16'(TIMEOUT_CYC - 1);
    assign err_timeout_o = err_q;

    // counts every cycle of one op, request and drop phases together
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
            err_q   <= 1'b0;
        end else begin
            tmo_cnt <= busy ? tmo_cnt + 16'd1 : 16'd0;
            err_q   <= err_q || tmo;
        end
    end
`else
    assign tmo           = 1'b0;
    assign err_timeout_o = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:                state_d = inv_gnt ? FLUSH : fill_gnt ? FILL : lkup_gnt ? LOOKUP : IDLE;
            LOOKUP, FILL, FLUSH,
            DROP:                state_d = fin ? ((op_q == LOOKUP) ? RSP : IDLE)
                                               : (req_st && op_done) ? DROP : state_q;
            RSP:                 state_d = rsp_ready_i ? IDLE : RSP;
            default:             state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            op_q       <= IDLE;
            did_q      <= '0;
            pid_q      <= '0;
            fill_ctx_q <= '0;
            hit_q      <= 1'b0;
            rsp_ctx_q  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE)
                op_q <= state_d;
            if (inv_gnt || fill_gnt || lkup_gnt) begin
                did_q <= inv_gnt ? inv_did_i : fill_gnt ? fill_did_i : lkup_did_i;
                pid_q <= inv_gnt ? inv_pid_i : fill_gnt ? fill_pid_i : lkup_pid_i;
            end
            if (fill_gnt)
                fill_ctx_q <= fill_ctx_i;
            // a timed-out lookup reports a miss regardless of what was captured
            if (tmo) begin
                hit_q     <= 1'b0;
                rsp_ctx_q <= '0;
            end else if (state_q == LOOKUP && pdtc_lkup_fill_done_i) begin
                hit_q     <= pdtc_hit_i;
                rsp_ctx_q <= pdtc_hit_i ? pdtc_ctx_i : '0;
            end
        end
    end

    assign inv_ready_o   = inv_gnt;
    assign fill_ready_o  = fill_gnt;
    assign lkup_ready_o  = lkup_gnt;
    assign pdtc_lookup_o = state_q == LOOKUP;
    assign pdtc_fill_o   = state_q == FILL;
    assign pdtc_flush_o  = state_q == FLUSH;
    assign pdtc_did_o    = did_q;
    assign pdtc_pid_o    = pid_q;
    assign pdtc_ctx_o    = fill_ctx_q;
    assign inv_done_o    = fin && op_q == FLUSH;
    assign rsp_valid_o   = state_q == RSP;
    assign rsp_hit_o     = hit_q;
    assign rsp_ctx_o     = rsp_ctx_q;
endmodule

// File: tb/tb_rv_iommu_pdtc_ctrl.sv
// tb_rv_iommu_pdtc_ctrl: scoreboard bench with a behavioural 4-entry cache stub.
// Timeout checks run only when RV_IOMMU_PDTC_TIMEOUT_EN is defined.
module tb_rv_iommu_pdtc_ctrl;
    import rv_iommu_pkg::*;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             lkup_valid_i = 1'b0, lkup_ready_o;
    logic [DID_W-1:0] lkup_did_i = '0;
    logic [PID_W-1:0] lkup_pid_i = '0;
    logic             rsp_valid_o, rsp_ready_i = 1'b1, rsp_hit_o;
    logic [CTX_W-1:0] rsp_ctx_o;
    logic             fill_valid_i = 1'b0, fill_ready_o;
    logic [DID_W-1:0] fill_did_i = '0;
    logic [PID_W-1:0] fill_pid_i = '0;
    logic [CTX_W-1:0] fill_ctx_i = '0;
    logic             inv_valid_i = 1'b0, inv_ready_o, inv_done_o;
    logic [DID_W-1:0] inv_did_i = '0;
    logic [PID_W-1:0] inv_pid_i = '0;
    logic             pdtc_lookup_o, pdtc_fill_o, pdtc_flush_o;
    logic [DID_W-1:0] pdtc_did_o;
    logic [PID_W-1:0] pdtc_pid_o;
    logic [CTX_W-1:0] pdtc_ctx_o;
    logic             lf_done, fl_done, c_hit;
    logic [CTX_W-1:0] c_ctx;
    logic             err_timeout_o;

    int               n_tests = 0, n_fail = 0, inv_cnt = 0;
    logic [60:0]      sb[$];
    logic [1:0]       glog[$];
    logic [CTX_W-1:0] last_ctx;
    logic             stub_en = 1'b1;

    logic             cv[4];
    logic [DID_W-1:0] cd[4];
    logic [PID_W-1:0] cp[4];
    logic [CTX_W-1:0] cc[4];
    logic [1:0]       ptr;
    logic             hit_n;
    logic [CTX_W-1:0] ctx_n;

    always #5 clk = ~clk;

    rv_iommu_pdtc_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .lkup_valid_i(lkup_valid_i), .lkup_ready_o(lkup_ready_o),
        .lkup_did_i(lkup_did_i), .lkup_pid_i(lkup_pid_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_hit_o(rsp_hit_o), .rsp_ctx_o(rsp_ctx_o),
        .fill_valid_i(fill_valid_i), .fill_ready_o(fill_ready_o),
        .fill_did_i(fill_did_i), .fill_pid_i(fill_pid_i), .fill_ctx_i(fill_ctx_i),
        .inv_valid_i(inv_valid_i), .inv_ready_o(inv_ready_o),
        .inv_did_i(inv_did_i), .inv_pid_i(inv_pid_i), .inv_done_o(inv_done_o),
        .pdtc_lookup_o(pdtc_lookup_o), .pdtc_fill_o(pdtc_fill_o), .pdtc_flush_o(pdtc_flush_o),
        .pdtc_did_o(pdtc_did_o), .pdtc_pid_o(pdtc_pid_o), .pdtc_ctx_o(pdtc_ctx_o),
        .pdtc_lkup_fill_done_i(lf_done), .pdtc_hit_i(c_hit),
        .pdtc_flush_done_i(fl_done), .pdtc_ctx_i(c_ctx),
        .err_timeout_o(err_timeout_o)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // cache stub: done follows the request level one cycle later; misses return junk context
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lf_done <= 1'b0;
            fl_done <= 1'b0;
            c_hit   <= 1'b0;
            c_ctx   <= '0;
            ptr     <= '0;
            for (int i = 0; i < 4; i++) cv[i] <= 1'b0;
        end else if (stub_en) begin
            if (pdtc_lookup_o && !lf_done) begin
                hit_n = 1'b0;
                ctx_n = CTX_W'({$urandom, $urandom});
                for (int i = 0; i < 4; i++)
                    if (cv[i] && cd[i] == pdtc_did_o && cp[i] == pdtc_pid_o) begin
                        hit_n = 1'b1;
                        ctx_n = cc[i];
                    end
                c_hit   <= hit_n;
                c_ctx   <= ctx_n;
                lf_done <= 1'b1;
            end else if (pdtc_fill_o && !lf_done) begin
                cv[ptr] <= 1'b1;
                cd[ptr] <= pdtc_did_o;
                cp[ptr] <= pdtc_pid_o;
                cc[ptr] <= pdtc_ctx_o;
                ptr     <= ptr + 2'd1;
                lf_done <= 1'b1;
            end else if (!pdtc_lookup_o && !pdtc_fill_o)
                lf_done <= 1'b0;
            if (pdtc_flush_o && !fl_done) begin
                for (int i = 0; i < 4; i++)
                    if (cd[i] == pdtc_did_o && cp[i] == pdtc_pid_o) cv[i] <= 1'b0;
                fl_done <= 1'b1;
            end else if (!pdtc_flush_o)
                fl_done <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("one_req", 64'(int'(pdtc_lookup_o) + int'(pdtc_fill_o) + int'(pdtc_flush_o) > 1), 64'd0);
            if (inv_ready_o)  glog.push_back(2'd0);
            if (fill_ready_o) glog.push_back(2'd1);
            if (lkup_ready_o) glog.push_back(2'd2);
            if (inv_done_o)   inv_cnt++;
            if (rsp_valid_o && rsp_ready_i) begin
                if (sb.size() == 0)
                    chk("sb_unexpected_rsp", 64'd1, 64'd0);
                else begin
                    logic [60:0] e;
                    e = sb.pop_front();
                    chk("rsp_hit", 64'(rsp_hit_o), 64'(e[60]));
                    chk("rsp_ctx", 64'(rsp_ctx_o), 64'(e[59:0]));
                    last_ctx = rsp_ctx_o;
                end
            end
        end
    end

    // k: 0 flush, 1 fill, 2 lookup
    task automatic send(input int k, input logic [23:0] did, input logic [19:0] pid, input logic [59:0] ctx);
        logic ok = 1'b0;
        @(posedge clk); #1;
        case (k)
            0:       begin inv_valid_i = 1'b1;  inv_did_i = did;  inv_pid_i = pid; end
            1:       begin fill_valid_i = 1'b1; fill_did_i = did; fill_pid_i = pid; fill_ctx_i = ctx; end
            default: begin lkup_valid_i = 1'b1; lkup_did_i = did; lkup_pid_i = pid; end
        endcase
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if ((k == 0 && inv_ready_o) || (k == 1 && fill_ready_o) || (k == 2 && lkup_ready_o)) begin
                ok = 1'b1;
                break;
            end
        end
        chk("grant_wait", 64'(ok), 64'd1);
        @(posedge clk); #1;
        case (k)
            0:       inv_valid_i = 1'b0;
            1:       fill_valid_i = 1'b0;
            default: lkup_valid_i = 1'b0;
        endcase
    endtask

    task automatic lookup(input logic [23:0] did, input logic [19:0] pid, input logic hit, input logic [59:0] ctx);
        sb.push_back({hit, ctx});
        send(2, did, pid, '0);
    endtask

    task automatic drain();
        for (int i = 0; i < 400 && sb.size() != 0; i++) @(negedge clk);
        chk("drain", 64'(sb.size()), 64'd0);
        repeat (3) @(posedge clk);
    endtask

    function automatic logic [13:0] order(input int n0, input int cnt);
        logic [13:0] r = '0;
        for (int i = 0; i < cnt; i++) r = {r[11:0], (n0 + i < glog.size()) ? glog[n0 + i] : 2'd3};
        return r;
    endfunction

    pdtc_ctx_t ca, cb, cy, cz;
    int        n0, ni;

    initial begin
        ca = '{ens: 1'b1, sum: 1'b0, pscid: 20'h00abc, fsc_mode: 4'h8, fsc_ppn: 34'h2_0000_1234};
        cb = '{ens: 1'b0, sum: 1'b1, pscid: 20'h12345, fsc_mode: 4'h9, fsc_ppn: 34'h0_dead_beef};
        cy = '{ens: 1'b1, sum: 1'b1, pscid: 20'hfffff, fsc_mode: 4'ha, fsc_ppn: 34'h3_ffff_0001};
        cz = '{ens: 1'b1, sum: 1'b0, pscid: 20'h00777, fsc_mode: 4'h8, fsc_ppn: 34'h1_2345_6789};
        repeat (3) @(posedge clk);
        chk("reset_outs", 64'({lkup_ready_o, fill_ready_o, inv_ready_o, rsp_valid_o, inv_done_o,
                               pdtc_lookup_o, pdtc_fill_o, pdtc_flush_o, err_timeout_o}), 64'd0);
        #1 rst_n = 1'b1;

        // lookup miss on an empty cache, request level held through done
        lookup(24'h12, 20'h5, 1'b0, '0);
        @(negedge clk);
        chk("lk_level", 64'({pdtc_lookup_o, pdtc_did_o, pdtc_pid_o}), 64'({1'b1, 24'h12, 20'h5}));
        for (int i = 0; i < 20 && !lf_done; i++) @(negedge clk);
        chk("lk_hold_at_done", 64'(pdtc_lookup_o), 64'd1);
        @(negedge clk);
        chk("lk_dropped", 64'(pdtc_lookup_o), 64'd0);
        drain();

        // fill then lookup of the same tags hits with the filled context
        send(1, 24'h34, 20'h6, ca);
        lookup(24'h34, 20'h6, 1'b1, ca);
        drain();
        chk("hit_ppn", 64'(last_ctx[33:0]), 64'h2_0000_1234);

        // response held while rsp_ready is low and no new grant is made
        rsp_ready_i = 1'b0;
        lookup(24'h34, 20'h6, 1'b1, ca);
        for (int i = 0; i < 50 && !rsp_valid_o; i++) @(negedge clk);
        n0 = glog.size();
        fork
            send(1, 24'h99, 20'h9, cb);
            begin
                repeat (4) @(negedge clk);
                chk("rsp_hold", 64'({rsp_valid_o, rsp_hit_o}), 64'b11);
                chk("rsp_no_grant", 64'(glog.size()), 64'(n0));
                @(posedge clk); #1 rsp_ready_i = 1'b1;
            end
        join
        drain();

        // simultaneous requests: flush, then fill, then lookup
        n0 = glog.size();
        sb.push_back({1'b1, cy});
        fork
            send(0, 24'h55, 20'h1, '0);
            send(1, 24'h66, 20'h2, cy);
            send(2, 24'h66, 20'h2, '0);
        join
        drain();
        chk("prio_order", 64'(order(n0, 3)), 64'({2'd0, 2'd1, 2'd2}));

        // starvation: lookup forced after exactly four fills
        n0 = glog.size();
        sb.push_back({1'b0, 60'd0});
        fork
            send(2, 24'habc, 20'h3, '0);
            for (int i = 0; i < 6; i++) send(1, 24'h100 + 24'(i), 20'h7, cb);
        join
        drain();
        chk("starve_order", 64'(order(n0, 7)),
            64'({2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd1, 2'd1}));

        // flush of a filled entry: done pulse, then miss
        send(1, 24'h77, 20'h8, cz);
        lookup(24'h77, 20'h8, 1'b1, cz);
        drain();
        ni = inv_cnt;
        send(0, 24'h77, 20'h8, '0);
        repeat (10) @(posedge clk);
        chk("inv_done", 64'(inv_cnt - ni), 64'd1);
        lookup(24'h77, 20'h8, 1'b0, '0);
        drain();

`ifdef RV_IOMMU_PDTC_TIMEOUT_EN
        stub_en = 1'b0;
        lookup(24'h88, 20'h1, 1'b0, '0);
        drain();
        chk("err_timeout", 64'(err_timeout_o), 64'd1);
        stub_en = 1'b1;
`endif

        // reset during LOOKUP drops every request level at once
        stub_en = 1'b0;
        send(2, 24'h42, 20'h4, '0);
        repeat (3) @(negedge clk);
        chk("lk_stuck", 64'(pdtc_lookup_o), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("reset_mid_op", 64'({lkup_ready_o, fill_ready_o, inv_ready_o, rsp_valid_o, inv_done_o,
                                 pdtc_lookup_o, pdtc_fill_o, pdtc_flush_o, err_timeout_o}), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        stub_en = 1'b1;

        lookup(24'h12, 20'h5, 1'b0, '0);
        drain();
        chk("err_final", 64'(err_timeout_o), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
